priv_trap_ctrl: RTL and testbench
=================================

Name: priv_trap_ctrl

Overview:
- Machine-mode trap sequencer. It sits between the commit stage and the machine-mode CSR file.
- Arbitrates synchronous exceptions, M-mode interrupts (MEI/MSI/MTI) and MRET.
- Owns priv level, mstatus MIE/MPIE/MPP, mepc, mcause and mtval.
- Drives a flush/redirect handshake to the pipeline and computes the trap vector from mtvec (DIRECT/VECTORED).

Parameters:
- HAS_U_MODE, 1, U-mode supported; when 0, MPP is hardwired to M_MODE (2'h3) and MRET always returns to M.
- XLEN, 32, register width; only 32 is supported.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- ex_valid  in  1  commit stage reports an exception this cycle
- ex_code  in  31  exception code (ex_code_t encoding)
- ex_epc  in  32  PC of the faulting instruction
- ex_tval  in  32  trap value
- mret_valid  in  1  MRET committing
- ext_int, soft_int, timer_int  in  1 each  level-sensitive M-mode interrupt sources
- meie, msie, mtie  in  1 each  mie enable bits from the CSR file
- mtvec  in  32  {base[29:0], mode[1:0]}
- csr_wr_en  in  1  CSR write strobe
- csr_wr_addr  in  12  CSR address
- csr_wr_data  in  32  CSR write data
- flush_ack  in  1  pipeline drained
- flush_req  out  1  request pipeline flush
- redirect_valid  out  1  one-cycle fetch redirect
- redirect_pc  out  32  redirect target
- trap_busy  out  1  high when FSM is not IDLE; commit stage stalls
- priv  out  2  current privilege (priv_level_t)
- mstatus_mie, mstatus_mpie  out  1 each
- mstatus_mpp  out  2
- mepc, mcause, mtval  out  32 each

Behaviour:
- Reset values (on the cycle RST is sampled high):
  - State IDLE; flush_req, redirect_valid, trap_busy = 0; redirect_pc = 0.
  - priv = M_MODE; mie = mpie = 0; mpp = M_MODE.
  - mepc, mcause, mtval = 0.
- RST mid-sequence aborts to IDLE with the values above; no CSR update occurs.
- Interrupt eligibility: pend = {ext_int&meie, soft_int&msie, timer_int&mtie}. Global enable = (priv != M_MODE) | mstatus_mie.
- Priority in IDLE: ex_valid > MRET > MEI (11) > MSI (3) > MTI (7). Exactly one event is latched. A lower-priority event that is simultaneously present is not queued; level interrupts are re-evaluated on the next IDLE cycle.
- FSM states:
  - IDLE: on an event, latch kind/cause/epc/tval and go to FLUSH. flush_req and trap_busy assert on the next cycle.
    - Exception latch: epc = ex_epc, tval = ex_tval, cause = {0, ex_code}.
    - Interrupt latch: epc = ex_epc (PC of next uncommitted instruction, supplied by the commit stage), tval = 0, cause = {1, code}.
    - MRET latch: no cause is latched.
  - FLUSH: hold flush_req = 1 until flush_ack is sampled high, then go to REDIRECT. Any ex/mret/int inputs in this state are ignored. flush_ack in IDLE is ignored.
  - REDIRECT: lasts one cycle. flush_req = 0, redirect_valid = 1, then IDLE.
    - Trap: at the clock edge ending REDIRECT, registers update: mepc = {epc[31:2], 2'b00}, mcause = cause, mtval = tval, mpie = mie, mie = 0, mpp = priv, priv = M_MODE.
    - Trap redirect_pc: mtvec.mode == VECTORED and interrupt → {base, 2'b00} + 4*cause[4:0]. Otherwise (exception, or mode DIRECT/RES_0/RES_1) → {base, 2'b00}.
    - MRET: redirect_pc = mepc. At the edge: priv = mpp, mie = mpie, mpie = 1, mpp = U_MODE if HAS_U_MODE else M_MODE.
- Total latency from event to redirect_valid is 2 cycles plus the number of cycles flush_req waits for flush_ack. If flush_ack is already high on the first FLUSH cycle, redirect_valid asserts 2 cycles after the event.
- CSR writes (take effect at the next edge):
  - Accepted in IDLE only; dropped while trap_busy is high.
  - MSTATUS (0x300): update mie (bit 3), mpie (bit 7) and mpp (bits 12:11). MPP is WARL: values 2'h1 or 2'h2, or 2'h0 when HAS_U_MODE = 0, leave the old value unchanged.
  - MEPC (0x341): bits [1:0] forced to 0.
  - MCAUSE (0x342) and MTVAL (0x343): full width.
  - Other addresses: ignored.
  - A CSR write and an event in the same IDLE cycle: the write is applied, and the event is latched in the same cycle.
- All outputs are registered. The owned-register outputs reflect current register values.

Test Plan:
- Reset, then ex_valid with ex_code = 2 (ILLEGAL_INSN), ex_epc = 0x80000104, ex_tval = 0x00000013, mtvec = 0x80001000 (DIRECT), flush_ack tied high → flush_req 1 cycle, redirect_valid with redirect_pc = 0x80001000; after: mepc = 0x80000104, mcause = 0x00000002, mtval = 0x13, priv = 3, mpp = 3, mie = 0.
- Write mstatus = 0x8; mtvec = 0x80001001 (VECTORED); meie = 1, ext_int = 1 → redirect_pc = 0x8000102C, mcause = 0x8000000B, mpie = 1, mie = 0.
- ext_int, soft_int and timer_int all pending with all enables set → cause 11 taken. With mie = 0, priv = M, timer_int pending → no trap.
- MRET with mpp = 0, mpie = 1, mepc = 0x80000200, HAS_U_MODE = 1 → redirect_pc = 0x80000200, priv = 0, mie = 1, mpie = 1, mpp = 0.
- Hold flush_ack low for 5 cycles → flush_req held 5 cycles, redirect_valid exactly once. A new ex_valid during FLUSH is ignored. A csr_wr_en to mepc during FLUSH is dropped.
- Assert RST during FLUSH → next cycle flush_req = 0 and all registers at reset values. Write mstatus MPP = 2'h2 → mpp unchanged.

Source files
------------

// File: rtl/priv_trap_ctrl.sv
// Machine-mode trap sequencer: arbitrates exceptions, M-mode interrupts and MRET,
// sequences flush/redirect to the pipeline and owns priv, mstatus, mepc, mcause, mtval.
module priv_trap_ctrl #(
  parameter bit HAS_U_MODE = 1'b1,
  parameter int XLEN       = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            ex_valid,
  input  logic [XLEN-2:0] ex_code,
  input  logic [XLEN-1:0] ex_epc,
  input  logic [XLEN-1:0] ex_tval,
  input  logic            mret_valid,
  input  logic            ext_int,
  input  logic            soft_int,
  input  logic            timer_int,
  input  logic            meie,
  input  logic            msie,
  input  logic            mtie,
  input  logic [XLEN-1:0] mtvec,
  input  logic            csr_wr_en,
  input  logic [11:0]     csr_wr_addr,
  input  logic [XLEN-1:0] csr_wr_data,
  input  logic            flush_ack,
  output logic            flush_req,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            trap_busy,
  output logic [1:0]      priv,
  output logic            mstatus_mie,
  output logic            mstatus_mpie,
  output logic [1:0]      mstatus_mpp,
  output logic [XLEN-1:0] mepc,
  output logic [XLEN-1:0] mcause,
  output logic [XLEN-1:0] mtval
);

  localparam logic [1:0]  M_MODE         = 2'h3;
  localparam logic [1:0]  U_MODE         = 2'h0;
  localparam logic [1:0]  MTVEC_VECTORED = 2'h1;
  localparam logic [11:0] CSR_MSTATUS    = 12'h300;
  localparam logic [11:0] CSR_MEPC       = 12'h341;
  localparam logic [11:0] CSR_MCAUSE     = 12'h342;
  localparam logic [11:0] CSR_MTVAL      = 12'h343;

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_REDIR} state_t;

  state_t          state_q;
  logic            flush_req_q, redirect_valid_q, busy_q;
  logic [XLEN-1:0] redirect_pc_q;
  logic [1:0]      priv_q, mpp_q;
  logic            mie_q, mpie_q;
  logic [XLEN-1:0] mepc_q, mcause_q, mtval_q;
  logic            ev_int_q, ev_mret_q;
  logic [XLEN-1:0] ev_epc_q, ev_tval_q, ev_cause_q;

  logic [2:0] pend;
  logic       gie, irq_take, ev_take;
  logic [4:0] irq_code;

  function automatic logic [1:0] mpp_warl(input logic [1:0] wr, input logic [1:0] old);
    if (wr == M_MODE || (HAS_U_MODE && wr == U_MODE)) return wr;
    return old;
  endfunction

  function automatic logic [XLEN-1:0] trap_target(input logic [XLEN-1:0] tvec,
                                                  input logic is_int,
                                                  input logic [4:0] code);
    logic [XLEN-1:0] base;
    base = {tvec[XLEN-1:2], 2'b00};
    if (is_int && tvec[1:0] == MTVEC_VECTORED)
      return base + {{(XLEN-7){1'b0}}, code, 2'b00};
    return base;
  endfunction

  // Fixed interrupt priority MEI > MSI > MTI; gated by global enable.
  always_comb begin
    pend     = {ext_int & meie, soft_int & msie, timer_int & mtie};
    gie      = (priv_q != M_MODE) | mie_q;
    irq_take = gie & (|pend);
    if (pend[2])      irq_code = 5'd11;
    else if (pend[1]) irq_code = 5'd3;
    else              irq_code = 5'd7;
    ev_take  = ex_valid | mret_valid | irq_take;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q          <= S_IDLE;
      flush_req_q      <= 1'b0;
      redirect_valid_q <= 1'b0;
      busy_q           <= 1'b0;
      redirect_pc_q    <= '0;
      priv_q           <= M_MODE;
      mie_q            <= 1'b0;
      mpie_q           <= 1'b0;
      mpp_q            <= M_MODE;
      mepc_q           <= '0;
      mcause_q         <= '0;
      mtval_q          <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (csr_wr_en) begin
            case (csr_wr_addr)
              CSR_MSTATUS: begin
                mie_q  <= csr_wr_data[3];
                mpie_q <= csr_wr_data[7];
                mpp_q  <= mpp_warl(csr_wr_data[12:11], mpp_q);
              end
              CSR_MEPC:   mepc_q   <= {csr_wr_data[XLEN-1:2], 2'b00};
              CSR_MCAUSE: mcause_q <= csr_wr_data;
              CSR_MTVAL:  mtval_q  <= csr_wr_data;
              default: ;
            endcase
          end
          // Only the winning event is latched; losers are not queued.
          if (ev_take) begin
            state_q     <= S_FLUSH;
            flush_req_q <= 1'b1;
            busy_q      <= 1'b1;
            ev_mret_q   <= !ex_valid && mret_valid;
            ev_int_q    <= !ex_valid && !mret_valid;
            ev_epc_q    <= ex_epc;
            ev_tval_q   <= ex_valid ? ex_tval : '0;
            ev_cause_q  <= ex_valid ? {1'b0, ex_code} : {1'b1, {(XLEN-6){1'b0}}, irq_code};
          end
        end
        S_FLUSH: begin
          if (flush_ack) begin
            state_q          <= S_REDIR;
            flush_req_q      <= 1'b0;
            redirect_valid_q <= 1'b1;
            redirect_pc_q    <= ev_mret_q ? mepc_q : trap_target(mtvec, ev_int_q, ev_cause_q[4:0]);
          end
        end
        S_REDIR: begin
          state_q          <= S_IDLE;
          redirect_valid_q <= 1'b0;
          busy_q           <= 1'b0;
          if (ev_mret_q) begin
            priv_q <= mpp_q;
            mie_q  <= mpie_q;
            mpie_q <= 1'b1;
            mpp_q  <= HAS_U_MODE ? U_MODE : M_MODE;
          end else begin
            mepc_q   <= {ev_epc_q[XLEN-1:2], 2'b00};
            mcause_q <= ev_cause_q;
            mtval_q  <= ev_tval_q;
            mpie_q   <= mie_q;
            mie_q    <= 1'b0;
            mpp_q    <= priv_q;
            priv_q   <= M_MODE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign flush_req      = flush_req_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign trap_busy      = busy_q;
  assign priv           = priv_q;
  assign mstatus_mie    = mie_q;
  assign mstatus_mpie   = mpie_q;
  assign mstatus_mpp    = mpp_q;
  assign mepc           = mepc_q;
  assign mcause         = mcause_q;
  assign mtval          = mtval_q;

endmodule

// File: tb/tb_priv_trap_ctrl.sv
// Randomized bench for priv_trap_ctrl against a transaction-level architectural model.
module tb_priv_trap_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ex_valid, mret_valid;
  logic [30:0] ex_code;
  logic [31:0] ex_epc, ex_tval, mtvec, csr_wr_data;
  logic        ext_int, soft_int, timer_int, meie, msie, mtie;
  logic        csr_wr_en, flush_ack;
  logic [11:0] csr_wr_addr;
  logic        flush_req, redirect_valid, trap_busy;
  logic [31:0] redirect_pc, mepc, mcause, mtval;
  logic [1:0]  priv, mstatus_mpp;
  logic        mstatus_mie, mstatus_mpie;

  always #5 CLK = ~CLK;

  priv_trap_ctrl #(.HAS_U_MODE(1'b1), .XLEN(32)) dut (
    .CLK(CLK), .RST(RST),
    .ex_valid(ex_valid), .ex_code(ex_code), .ex_epc(ex_epc), .ex_tval(ex_tval),
    .mret_valid(mret_valid),
    .ext_int(ext_int), .soft_int(soft_int), .timer_int(timer_int),
    .meie(meie), .msie(msie), .mtie(mtie),
    .mtvec(mtvec),
    .csr_wr_en(csr_wr_en), .csr_wr_addr(csr_wr_addr), .csr_wr_data(csr_wr_data),
    .flush_ack(flush_ack),
    .flush_req(flush_req), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .trap_busy(trap_busy), .priv(priv),
    .mstatus_mie(mstatus_mie), .mstatus_mpie(mstatus_mpie), .mstatus_mpp(mstatus_mpp),
    .mepc(mepc), .mcause(mcause), .mtval(mtval)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // Architectural model state
  logic [1:0]  m_priv, m_mpp;
  logic        m_mie, m_mpie;
  logic [31:0] m_mepc, m_mcause, m_mtval;
  logic [31:0] last_rpc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_priv = 2'd3; m_mpp = 2'd3; m_mie = 1'b0; m_mpie = 1'b0;
    m_mepc = '0; m_mcause = '0; m_mtval = '0;
  endtask

  task automatic chk_arch(input string tag);
    chk({tag, "_priv"},   32'(priv),         32'(m_priv));
    chk({tag, "_mie"},    32'(mstatus_mie),  32'(m_mie));
    chk({tag, "_mpie"},   32'(mstatus_mpie), 32'(m_mpie));
    chk({tag, "_mpp"},    32'(mstatus_mpp),  32'(m_mpp));
    chk({tag, "_mepc"},   mepc,   m_mepc);
    chk({tag, "_mcause"}, mcause, m_mcause);
    chk({tag, "_mtval"},  mtval,  m_mtval);
  endtask

  function automatic logic [11:0] pick_addr();
    case ($urandom_range(0, 4))
      0:       return 12'h300;
      1:       return 12'h341;
      2:       return 12'h342;
      3:       return 12'h343;
      default: return 12'h305;
    endcase
  endfunction

  task automatic quiet();
    RST = 1'b0; ex_valid = 1'b0; mret_valid = 1'b0; ex_code = '0; ex_epc = '0; ex_tval = '0;
    ext_int = 1'b0; soft_int = 1'b0; timer_int = 1'b0; meie = 1'b0; msie = 1'b0; mtie = 1'b0;
    csr_wr_en = 1'b0; csr_wr_addr = '0; csr_wr_data = '0; flush_ack = 1'b0;
  endtask

  // Noise while busy: all of it must be ignored (mtvec is left alone).
  task automatic scramble();
    ex_valid = 1'($urandom); mret_valid = 1'($urandom); ex_code = 31'($urandom);
    ex_epc = $urandom; ex_tval = $urandom;
    ext_int = 1'($urandom); soft_int = 1'($urandom); timer_int = 1'($urandom);
    meie = 1'($urandom); msie = 1'($urandom); mtie = 1'($urandom);
    csr_wr_en = 1'($urandom); csr_wr_addr = pick_addr(); csr_wr_data = $urandom;
  endtask

  // One IDLE cycle with the currently driven inputs, followed by the full
  // flush/redirect sequence if the model says an event is taken.
  task automatic txn(input int ack_low);
    int          ev;
    logic        gie;
    logic [2:0]  pnd;
    logic [31:0] c, e, t, pc;
    ev = 0; c = '0; e = '0; t = '0;
    gie = (m_priv != 2'd3) || m_mie;
    pnd = {ext_int & meie, soft_int & msie, timer_int & mtie};
    if (ex_valid) begin
      ev = 1; c = {1'b0, ex_code}; e = ex_epc; t = ex_tval;
    end else if (mret_valid) begin
      ev = 3;
    end else if (gie && pnd != 3'b000) begin
      ev = 2; e = ex_epc; t = 32'h0;
      c = pnd[2] ? 32'h8000000B : (pnd[1] ? 32'h80000003 : 32'h80000007);
    end
    if (csr_wr_en) begin
      case (csr_wr_addr)
        12'h300: begin
          m_mie  = csr_wr_data[3];
          m_mpie = csr_wr_data[7];
          if (csr_wr_data[12:11] == 2'd0 || csr_wr_data[12:11] == 2'd3) m_mpp = csr_wr_data[12:11];
        end
        12'h341: m_mepc   = csr_wr_data & ~32'h3;
        12'h342: m_mcause = csr_wr_data;
        12'h343: m_mtval  = csr_wr_data;
        default: ;
      endcase
    end
    if (ev == 3)                             pc = m_mepc;
    else if (ev == 2 && mtvec[1:0] == 2'b01) pc = (mtvec & ~32'h3) + ((c & 32'h1f) << 2);
    else                                     pc = mtvec & ~32'h3;

    @(posedge CLK); #1;
    if (ev == 0) begin
      chk("idle_flush_req", 32'(flush_req), 0);
      chk("idle_busy", 32'(trap_busy), 0);
      chk("idle_redirect", 32'(redirect_valid), 0);
      chk_arch("idle");
      quiet();
      return;
    end
    chk("flush_req_rise", 32'(flush_req), 1);
    chk("busy_rise", 32'(trap_busy), 1);
    chk("no_early_redirect", 32'(redirect_valid), 0);
    for (int i = 0; i < ack_low; i++) begin
      scramble(); flush_ack = 1'b0;
      @(posedge CLK); #1;
      chk("flush_hold", 32'(flush_req), 1);
      chk("flush_no_redirect", 32'(redirect_valid), 0);
    end
    scramble(); flush_ack = 1'b1;
    @(posedge CLK); #1;
    chk("redirect_valid", 32'(redirect_valid), 1);
    chk("redirect_pc", redirect_pc, pc);
    chk("redirect_flush_low", 32'(flush_req), 0);
    chk("redirect_busy", 32'(trap_busy), 1);
    chk_arch("pre_update");
    last_rpc = redirect_pc;
    scramble(); flush_ack = 1'($urandom);
    @(posedge CLK); #1;
    if (ev == 3) begin
      m_priv = m_mpp; m_mie = m_mpie; m_mpie = 1'b1; m_mpp = 2'd0;
    end else begin
      m_mepc = e & ~32'h3; m_mcause = c; m_mtval = t;
      m_mpie = m_mie; m_mie = 1'b0; m_mpp = m_priv; m_priv = 2'd3;
    end
    chk("post_redirect_low", 32'(redirect_valid), 0);
    chk("post_busy_low", 32'(trap_busy), 0);
    chk("post_flush_low", 32'(flush_req), 0);
    chk_arch("post");
    quiet();
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    quiet(); csr_wr_en = 1'b1; csr_wr_addr = a; csr_wr_data = d;
    txn(0);
  endtask

  initial begin
    quiet(); mtvec = 32'h0; last_rpc = '0;
    RST = 1'b1;
    ex_valid = 1'b1; ext_int = 1'b1; meie = 1'b1; flush_ack = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    model_reset();
    chk("rst_flush_req", 32'(flush_req), 0);
    chk("rst_redirect_valid", 32'(redirect_valid), 0);
    chk("rst_busy", 32'(trap_busy), 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk_arch("rst");
    quiet();

    // Illegal instruction, DIRECT vector, ack already high.
    mtvec = 32'h80001000;
    ex_valid = 1'b1; ex_code = 31'd2; ex_epc = 32'h80000104; ex_tval = 32'h13;
    txn(0);
    chk("tp1_rpc", last_rpc, 32'h80001000);
    chk("tp1_mepc", mepc, 32'h80000104);
    chk("tp1_mcause", mcause, 32'h2);
    chk("tp1_mtval", mtval, 32'h13);
    chk("tp1_mpp", 32'(mstatus_mpp), 3);

    // Vectored external interrupt.
    csr_write(12'h300, 32'h8);
    quiet(); mtvec = 32'h80001001; meie = 1'b1; ext_int = 1'b1; ex_epc = 32'h80000300;
    txn(0);
    chk("tp2_rpc", last_rpc, 32'h8000102C);
    chk("tp2_mcause", mcause, 32'h8000000B);
    chk("tp2_mpie", 32'(mstatus_mpie), 1);
    chk("tp2_mie", 32'(mstatus_mie), 0);

    // All three pending: MEI wins. Then globally disabled timer: no trap.
    csr_write(12'h300, 32'h8);
    quiet(); ext_int = 1'b1; soft_int = 1'b1; timer_int = 1'b1; meie = 1'b1; msie = 1'b1; mtie = 1'b1;
    txn(1);
    chk("tp3_mcause", mcause, 32'h8000000B);
    quiet(); timer_int = 1'b1; mtie = 1'b1;
    txn(0);
    chk("tp3_no_trap", 32'(trap_busy), 0);

    // MRET to U-mode.
    csr_write(12'h341, 32'h80000200);
    csr_write(12'h300, 32'h80);
    quiet(); mret_valid = 1'b1;
    txn(0);
    chk("tp4_rpc", last_rpc, 32'h80000200);
    chk("tp4_priv", 32'(priv), 0);
    chk("tp4_mie", 32'(mstatus_mie), 1);
    chk("tp4_mpie", 32'(mstatus_mpie), 1);
    chk("tp4_mpp", 32'(mstatus_mpp), 0);

    // Slow flush_ack with noise (new exceptions, mepc writes) during FLUSH.
    quiet(); mtvec = 32'h80001000;
    ex_valid = 1'b1; ex_code = 31'd5; ex_epc = 32'h80000444; ex_tval = 32'hDEAD0000;
    txn(5);

    // Reset in the middle of FLUSH.
    quiet(); ex_valid = 1'b1; ex_code = 31'd7; ex_epc = 32'h80000888;
    @(posedge CLK); #1;
    chk("rstmid_flush_rise", 32'(flush_req), 1);
    quiet(); RST = 1'b1; flush_ack = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0; flush_ack = 1'b0;
    model_reset();
    chk("rstmid_flush_req", 32'(flush_req), 0);
    chk("rstmid_busy", 32'(trap_busy), 0);
    chk("rstmid_redirect_valid", 32'(redirect_valid), 0);
    chk("rstmid_redirect_pc", redirect_pc, 0);
    chk_arch("rstmid");
    quiet(); flush_ack = 1'b1;
    txn(0);
    csr_write(12'h300, 32'h1000);
    chk("warl_mpp", 32'(mstatus_mpp), 3);

    // Randomized traffic.
    for (int n = 0; n < 250; n++) begin
      quiet();
      ex_valid    = ($urandom_range(0, 5) == 0);
      mret_valid  = ($urandom_range(0, 5) == 0);
      ex_code     = 31'($urandom);
      ex_epc      = $urandom;
      ex_tval     = $urandom;
      ext_int     = 1'($urandom); soft_int = 1'($urandom); timer_int = 1'($urandom);
      meie        = 1'($urandom); msie = 1'($urandom); mtie = 1'($urandom);
      csr_wr_en   = ($urandom_range(0, 2) == 0);
      csr_wr_addr = pick_addr();
      csr_wr_data = $urandom;
      mtvec       = $urandom;
      flush_ack   = 1'($urandom);
      txn($urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
